uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial UART receiver, 8N1, LSB first: the consumer on the far side of the tx line.
//  - Oversamples the incoming line with the system clock.
//  - Recovers each byte and presents it with a one-cycle strobe.
//  - Flags frames whose stop bit is low.
//  - Baud rate is set by the same divisor constants that the transmitter uses.
// PARAMETERS
//  M      `B115200 (104 @12 MHz)  clk cycles per bit, taken from baudgen.vh; must be >= 8
//  M_HALF M/2                     cycles from start-bit falling edge to the start-bit mid-sample
// PORTS
//  clk   in   1  system clock; everything is on posedge
//  rst   in   1  reset, asynchronous, active-high
//  rx    in   1  serial line, idle high, asynchronous to clk
//  data  out  8  last correctly received byte
//  rcv   out  1  one-cycle strobe: data has just been updated
//  ferr  out  1  one-cycle strobe: stop bit sampled low, frame discarded
//  busy  out  1  high while a frame is in progress (any state except IDLE)
// BEHAVIOUR
//  Reset values: data=8'h00, rcv=0, ferr=0, busy=0, state=IDLE.
//    The synchronizer FFs and the sampled-line register reset to 1.
//  Synchronizer: rx passes through 2 FFs before any use; the synchronized value is rx_s.
//  Baud counter:
//    - Cleared and held in IDLE.
//    - Loaded with M_HALF when IDLE exits, then with M after every tick.
//    - Tick = 1-cycle pulse when the counter reaches 0; the tick cycle is the sample point.
//  FSM states:
//    IDLE  rx_s==0 -> START (counter loaded with M_HALF).
//    START at tick: rx_s==1 -> IDLE (glitch rejected, no strobe);
//                   rx_s==0 -> DATA, bit index=0.
//    DATA  at each tick: shift rx_s into sh[7] (sh >> 1), index++;
//          after the 8th sample -> STOP.
//    STOP  at tick: rx_s==1 -> data<=sh, rcv=1 for the next cycle, -> IDLE;
//                   rx_s==0 -> ferr=1 for the next cycle, data unchanged, -> BRK.
//    BRK   stays until rx_s==1 -> IDLE; no re-trigger while the line is held low (break).
//  Latency:
//    - rcv rises 1 clk after the mid-stop-bit tick.
//    - Mid-stop-bit tick is ~9.5*M + 3 clk after the rx falling edge (2-FF sync plus register).
//  rcv and ferr are never high in the same cycle; each is high for exactly 1 cycle per frame.
//  Back-to-back frames:
//    - IDLE is re-entered at mid-stop, so the next start edge is detected with no lost frame.
//    - Tolerance is about +/-4% of baud mismatch.
//  data holds its value until the next good frame; there is no consumer handshake.
//    The consumer must latch data on rcv.
//  Reset mid-frame: everything returns to reset values immediately.
//    - Partial frame is discarded.
//    - If rx is low when reset is released, the FSM enters START at the first low sample.
//      That frame may be rejected or misread; no recovery guarantee beyond the next idle line.
//  Counter width: $clog2(M+1) bits; no wrap-around with M in range.
// STRUCTURE
//  Shared include baudgen.vh: the `B300..`B115200 divisor constants, unchanged and shared with tx.
//  State encodings are local localparams in uart_rx, not shared.
//  One sub-module, rx_baud_tick: counter with a load value (M_HALF on start, M after ticks),
//    an enable input (low forces clear) and a tick output.
//  Synchronizer, shifter and FSM live in uart_rx.
// TESTING (M=104 @12 MHz unless stated)
//  1. Send 0x43 ('C') framed 0,1100 0010,1 at M cycles/bit
//     -> single rcv pulse, data==8'h43, ferr==0, busy low after stop.
//  2. rx low for 30 clk then high (< M_HALF)
//     -> no rcv, no ferr, busy drops back to 0 after the START tick.
//  3. Frame 0x41 with stop bit driven 0, then rx held low 3*M
//     -> ferr pulse, data unchanged, rcv stays 0.
//     After rx goes high, frame 0x5A -> rcv, data==8'h5A.
//  4. Back-to-back 0x55,0xAA,0x00,0xFF with no idle gap
//     -> 4 rcv pulses in order with the matching data.
//     Repeat at bit period M+3 and M-3 -> same result.
//  5. Assert rst during bit 4 of a frame
//     -> data==0, rcv/ferr/busy==0 that cycle.
//     Next full frame 0x3C -> data==8'h3C.
//  6. Loopback: the tx continuous transmitter (load=1) drives rx
//     -> repeated rcv pulses every 10*M clk, data==8'h43 each time, no ferr.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared constants for the UART receiver.
//   - Baud divisors: system clock cycles per bit at a 12 MHz system clock.
//     These are the same values the transmitter uses, so the two ends agree.
//   - DATA_BITS: payload width of one 8N1 frame.
//   - half_bit(): cycles from the start-bit falling edge to the start-bit
//     mid-sample, used as the default for the receiver's M_HALF.
package uart_rx_pkg;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    localparam int DATA_BITS = 8;

    function automatic int half_bit(input int m);
        return m / 2;
    endfunction

endpackage

// File: rtl/rx_baud_tick.sv
// rx_baud_tick
//   Bit-timing counter for the UART receiver.
//   Ports:
//     clk    in   system clock
//     rst    in   asynchronous active-high reset
//     en     in   low clears the counter and holds it at zero
//     start  in   first cycle of a frame: load the half-bit interval
//     tick   out  one-cycle pulse marking a sample point
//   The load values are intervals in clock cycles: after start the first
//   tick comes M_HALF cycles later, and every following tick M cycles after
//   the previous one.
module rx_baud_tick #(
    parameter int M      = 104,
    parameter int M_HALF = 52
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    output logic tick
);

    localparam int CW = $clog2(M + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The counter is stored as "cycles left minus one", so the cycle in
    // which it sits at zero is the sample cycle and the reload of M-1
    // gives a tick period of exactly M clocks.
    always_comb begin
        tick    = 1'b0;
        count_d = count_q;
        if (!en) begin
            count_d = '0;
        end else if (start) begin
            count_d = CW'(M_HALF - 1);
        end else if (count_q == '0) begin
            tick    = 1'b1;
            count_d = CW'(M - 1);
        end else begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver, LSB first, oversampled by the system clock.
//   Ports:
//     clk   in   system clock, everything on posedge
//     rst   in   asynchronous active-high reset
//     rx    in   serial line, idle high, asynchronous to clk
//     data  out  last correctly received byte, held until the next good frame
//     rcv   out  one-cycle strobe: data has just been updated
//     ferr  out  one-cycle strobe: stop bit sampled low, frame discarded
//     busy  out  high while a frame is in progress (any state but IDLE)
//   A frame whose stop bit is low parks the receiver in BRK until the line
//   returns high, so a held-low line (break) does not produce a stream of
//   phantom frames.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int M      = B115200,
    parameter int M_HALF = half_bit(M)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       busy
);

    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 rx_meta_q;
    logic                 rx_meta_d;
    logic                 rx_s_q;
    logic                 rx_s_d;
    logic [DATA_BITS-1:0] sh_q;
    logic [DATA_BITS-1:0] sh_d;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        idx_d;
    logic [7:0]           data_q;
    logic [7:0]           data_d;
    logic                 rcv_q;
    logic                 rcv_d;
    logic                 ferr_q;
    logic                 ferr_d;

    logic                 baud_start;
    logic                 baud_en;
    logic                 tick;

    // Two-flop synchronizer; only rx_s_q is ever looked at by the FSM.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
    end

    // The bit timer only runs while a frame is being sampled; BRK just
    // waits for the line and needs no timing.
    always_comb begin
        baud_en = baud_start
                | (state_q == START)
                | (state_q == DATA)
                | (state_q == STOP);
    end

    rx_baud_tick #(
        .M      (M),
        .M_HALF (M_HALF)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .en    (baud_en),
        .start (baud_start),
        .tick  (tick)
    );

    // Next-state and strobe logic. The receiver returns to IDLE at the
    // mid-stop sample, leaving half a bit to catch the next start edge.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rcv_d      = 1'b0;
        ferr_d     = 1'b0;
        baud_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d    = START;
                    baud_start = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        // Line was high again at mid start bit: a glitch.
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sh_d = {rx_s_q, sh_q[DATA_BITS-1:1]};
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s_q) begin
                        data_d  = sh_q;
                        rcv_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. The synchronizer resets to the idle
    // line level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            sh_q      <= '0;
            idx_q     <= '0;
            data_q    <= 8'h00;
            rcv_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            sh_q      <= sh_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            rcv_q     <= rcv_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data = data_q;
    assign rcv  = rcv_q;
    assign ferr = ferr_q;
    assign busy = (state_q != IDLE);

endmodule
